// File: rtl/nmi_apb_pkg.sv
// Shared types and constants for the NMI-to-APB4 bridge.
package nmi_apb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;
  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_DECODE  = 2'd1,
    ERR_SLVERR  = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  // Slave index width; a single-slave map still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? int'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/nmi_apb_decoder.sv
// Combinational base/mask address decoder; lowest matching slave index wins.
module nmi_apb_decoder #(
  parameter int unsigned                   NUM_SLV    = 12,
  parameter int unsigned                   ADDR_WIDTH = 32,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE   = '0,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK   = '0,
  parameter int unsigned                   IDX_W      = 4
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  hit_o,
  output logic [NUM_SLV-1:0]    onehot_o,
  output logic [IDX_W-1:0]      idx_o
);

  // Walk from the top down so the lowest hitting index overwrites the rest.
  always_comb begin
    hit_o    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) == SLV_BASE[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit_o       = 1'b1;
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/nmi_apb_bridge.sv
// NMI-to-APB4 bridge: one transaction at a time, address decode, SETUP/ACCESS
// sequencing, and decode/slverr/timeout termination with a sticky error sideband.
module nmi_apb_bridge
  import nmi_apb_pkg::*;
#(
  parameter int unsigned                   NUM_SLV    = 12,
  parameter int unsigned                   ADDR_WIDTH = 32,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_BASE   = '0,
  parameter logic [NUM_SLV*ADDR_WIDTH-1:0] SLV_MASK   = '0,
  parameter int unsigned                   TIMEOUT    = 256,
  parameter logic [DATA_W-1:0]             ERR_RDATA  = ERR_RDATA_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  input  logic                        nmi_valid_i,
  input  logic                        nmi_instr_i,
  input  logic [ADDR_WIDTH-1:0]       nmi_addr_i,
  input  logic [DATA_W-1:0]           nmi_wdata_i,
  input  logic [STRB_W-1:0]           nmi_wstrb_i,
  output logic                        nmi_ready_o,
  output logic [DATA_W-1:0]           nmi_rdata_o,
  output logic [ADDR_WIDTH-1:0]       paddr_o,
  output logic [2:0]                  pprot_o,
  output logic [NUM_SLV-1:0]          psel_o,
  output logic                        penable_o,
  output logic                        pwrite_o,
  output logic [DATA_W-1:0]           pwdata_o,
  output logic [STRB_W-1:0]           pstrb_o,
  input  logic [NUM_SLV*DATA_W-1:0]   prdata_i,
  input  logic [NUM_SLV-1:0]          pready_i,
  input  logic [NUM_SLV-1:0]          pslverr_i,
  output logic                        err_o,
  output logic [1:0]                  err_type_o,
  output logic [ADDR_WIDTH-1:0]       err_addr_o
);

  localparam int unsigned IDX_W   = idx_width(NUM_SLV);
  localparam int unsigned CNT_W   = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_W-1:0]       pwdata_q, pwdata_d;
  logic [STRB_W-1:0]       pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_SLV-1:0]      psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    nmi_ready_q, nmi_ready_d;
  logic [DATA_W-1:0]       nmi_rdata_q, nmi_rdata_d;
  logic                    err_q, err_d;
  err_e                    err_type_q, err_type_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic                    dec_hit;
  logic [NUM_SLV-1:0]      dec_oh;
  logic [IDX_W-1:0]        dec_idx;
  logic                    pready_sel, pslverr_sel;
  logic [DATA_W-1:0]       prdata_sel;
  logic                    capture;
  logic                    to_expire;

  nmi_apb_decoder #(
    .NUM_SLV    (NUM_SLV),
    .ADDR_WIDTH (ADDR_WIDTH),
    .SLV_BASE   (SLV_BASE),
    .SLV_MASK   (SLV_MASK),
    .IDX_W      (IDX_W)
  ) u_decoder (
    .addr_i   (nmi_addr_i),
    .hit_o    (dec_hit),
    .onehot_o (dec_oh),
    .idx_o    (dec_idx)
  );

  // Response mux for the slave captured at request time.
  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < int'(NUM_SLV); i++) begin
      if (idx_q == IDX_W'(i)) begin
        pready_sel  = pready_i[i];
        pslverr_sel = pslverr_i[i];
        prdata_sel  = prdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  assign capture   = (state_q == IDLE) && nmi_valid_i;
  assign to_expire = (TIMEOUT != 0) && (cnt_q == CNT_W'(TO_LAST)) && !pready_sel;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (nmi_valid_i) state_d = dec_hit ? SETUP : RESP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready_sel || to_expire) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything visible at the ports is computed against state_d so it lands
  // registered in the same cycle the FSM enters the matching state.
  always_comb begin
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    pprot_d     = pprot_q;
    idx_d       = idx_q;
    psel_d      = '0;
    penable_d   = 1'b0;
    nmi_ready_d = 1'b0;
    nmi_rdata_d = '0;
    err_d       = 1'b0;
    err_type_d  = err_type_q;
    err_addr_d  = err_addr_q;
    cnt_d       = cnt_q;

    if (capture) begin
      paddr_d  = nmi_addr_i;
      pwrite_d = |nmi_wstrb_i;
      pwdata_d = nmi_wdata_i;
      pstrb_d  = nmi_wstrb_i;
      pprot_d  = {nmi_instr_i, 2'b00};
      idx_d    = dec_idx;
    end

    if ((state_d == SETUP) || (state_d == ACCESS)) psel_d = capture ? dec_oh : psel_q;
    penable_d = (state_d == ACCESS);

    if (state_d == SETUP) begin
      cnt_d = '0;
    end else if ((state_q == ACCESS) && !pready_sel && (TIMEOUT != 0)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_d == RESP) begin
      nmi_ready_d = 1'b1;
      if (state_q == IDLE) begin
        err_d       = 1'b1;
        err_type_d  = ERR_DECODE;
        err_addr_d  = nmi_addr_i;
        nmi_rdata_d = ERR_RDATA;
      end else if (!pready_sel) begin
        err_d       = 1'b1;
        err_type_d  = ERR_TIMEOUT;
        err_addr_d  = paddr_q;
        nmi_rdata_d = ERR_RDATA;
      end else if (pslverr_sel) begin
        err_d       = 1'b1;
        err_type_d  = ERR_SLVERR;
        err_addr_d  = paddr_q;
        nmi_rdata_d = ERR_RDATA;
      end else begin
        nmi_rdata_d = pwrite_q ? '0 : prdata_sel;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      pprot_q     <= '0;
      idx_q       <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      nmi_ready_q <= 1'b0;
      nmi_rdata_q <= '0;
      err_q       <= 1'b0;
      err_type_q  <= ERR_NONE;
      err_addr_q  <= '0;
      cnt_q       <= '0;
    end else begin
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      pprot_q     <= pprot_d;
      idx_q       <= idx_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      nmi_ready_q <= nmi_ready_d;
      nmi_rdata_q <= nmi_rdata_d;
      err_q       <= err_d;
      err_type_q  <= err_type_d;
      err_addr_q  <= err_addr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign nmi_ready_o = nmi_ready_q;
  assign nmi_rdata_o = nmi_rdata_q;
  assign paddr_o     = paddr_q;
  assign pprot_o     = pprot_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign err_o       = err_q;
  assign err_type_o  = err_type_q;
  assign err_addr_o  = err_addr_q;

endmodule

// File: tb/tb_nmi_apb_bridge.sv
// Randomized bench for nmi_apb_bridge against a transaction-level reference model.
module tb_nmi_apb_bridge;

  localparam int NS = 6;
  localparam int TO = 4;
  // Slaves 0..4 at 0xNN00_0000 (mask FF00_0000); slave 5 covers 0x0xxx_xxxx and overlaps 0..4.
  localparam logic [NS*32-1:0] BASES = {32'h0000_0000, 32'h0400_0000, 32'h0300_0000,
                                        32'h0200_0000, 32'h0100_0000, 32'h0000_0000};
  localparam logic [NS*32-1:0] MASKS = {32'hF000_0000, 32'hFF00_0000, 32'hFF00_0000,
                                        32'hFF00_0000, 32'hFF00_0000, 32'hFF00_0000};

  logic              clk, rst_n;
  logic              nmi_valid_i, nmi_instr_i;
  logic [31:0]       nmi_addr_i, nmi_wdata_i;
  logic [3:0]        nmi_wstrb_i;
  logic              nmi_ready_o;
  logic [31:0]       nmi_rdata_o, paddr_o, pwdata_o, err_addr_o;
  logic [2:0]        pprot_o;
  logic [NS-1:0]     psel_o, pready_i, pslverr_i;
  logic              penable_o, pwrite_o, err_o;
  logic [3:0]        pstrb_o;
  logic [NS*32-1:0]  prdata_i;
  logic [1:0]        err_type_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] slv_rd [NS];
  int          wait_n  = 0;
  int          acc_cnt;
  logic        slverr_flag = 1'b0;
  logic        late_rdy    = 1'b0;
  logic [NS-1:0] rdy_noise = '0;
  logic [NS-1:0] err_noise = '0;
  logic [1:0]  m_et = 2'd0;
  logic [31:0] m_ea = 32'd0;

  nmi_apb_bridge #(
    .NUM_SLV(NS), .ADDR_WIDTH(32), .SLV_BASE(BASES), .SLV_MASK(MASKS),
    .TIMEOUT(TO), .ERR_RDATA(32'hDEAD_BEEF)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .nmi_valid_i(nmi_valid_i), .nmi_instr_i(nmi_instr_i), .nmi_addr_i(nmi_addr_i),
    .nmi_wdata_i(nmi_wdata_i), .nmi_wstrb_i(nmi_wstrb_i),
    .nmi_ready_o(nmi_ready_o), .nmi_rdata_o(nmi_rdata_o),
    .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o),
    .pwrite_o(pwrite_o), .pwdata_o(pwdata_o), .pstrb_o(pstrb_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i),
    .err_o(err_o), .err_type_o(err_type_o), .err_addr_o(err_addr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: selected slave answers after wait_n extra ACCESS cycles; others emit noise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_cnt <= 0;
    else        acc_cnt <= penable_o ? acc_cnt + 1 : 0;
  end

  logic [NS-1:0] sel_rdy;
  assign sel_rdy   = (penable_o && acc_cnt == wait_n) ? psel_o : '0;
  assign pready_i  = sel_rdy | (rdy_noise & ~psel_o) | {NS{late_rdy}};
  assign pslverr_i = (slverr_flag ? sel_rdy : '0) | (err_noise & ~psel_o);

  always_comb begin
    prdata_i = '0;
    for (int i = 0; i < NS; i++) prdata_i[i*32 +: 32] = slv_rd[i];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] base_of(input int i);
    logic [31:0] b;
    b = 32'(i);
    return (i < 5) ? (b << 24) : 32'h0;
  endfunction

  function automatic logic [31:0] mask_of(input int i);
    return (i < 5) ? 32'hFF00_0000 : 32'hF000_0000;
  endfunction

  function automatic int ref_decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++)
      if ((a & mask_of(i)) == base_of(i)) return i;
    return -1;
  endfunction

  // One full request; wn >= TO means the slave never answers.
  task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb, input logic [31:0] wdata,
                         input logic instr, input int wn, input logic serr);
    int          idx, exp_lat, exp_acc, cyc, acc_seen, err_seen, got_lat;
    logic [31:0] exp_rd, got_rd;
    logic [1:0]  exp_et;
    logic [NS-1:0] exp_sel;
    logic        done;
    idx = ref_decode(addr);
    for (int i = 0; i < NS; i++) slv_rd[i] = $urandom;
    rdy_noise   = NS'($urandom);
    err_noise   = NS'($urandom);
    wait_n      = wn;
    slverr_flag = serr;
    exp_sel     = '0;
    if (idx < 0) begin
      exp_lat = 1; exp_acc = 0; exp_et = 2'd1; exp_rd = 32'hDEAD_BEEF;
    end else begin
      exp_sel[idx] = 1'b1;
      if (wn >= TO) begin
        exp_lat = 2 + TO; exp_acc = TO; exp_et = 2'd3; exp_rd = 32'hDEAD_BEEF;
      end else begin
        exp_lat = 3 + wn; exp_acc = wn + 1;
        exp_et  = serr ? 2'd2 : 2'd0;
        exp_rd  = serr ? 32'hDEAD_BEEF : ((wstrb != 0) ? 32'h0 : slv_rd[idx]);
      end
    end
    if (exp_et != 2'd0) begin m_et = exp_et; m_ea = addr; end

    @(negedge clk);
    nmi_valid_i = 1'b1; nmi_addr_i = addr; nmi_wstrb_i = wstrb;
    nmi_wdata_i = wdata; nmi_instr_i = instr;
    cyc = 0; acc_seen = 0; err_seen = 0; done = 1'b0; got_lat = -1; got_rd = '0;
    while (!done && cyc < 400) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (psel_o != '0) begin
        check("psel", 64'(psel_o), 64'(exp_sel));
        check("paddr", 64'(paddr_o), 64'(addr));
        check("pwrite", 64'(pwrite_o), 64'(wstrb != 0));
        check("pstrb", 64'(pstrb_o), 64'(wstrb));
        check("pprot", 64'(pprot_o), 64'({instr, 2'b00}));
        if (wstrb != 0) check("pwdata", 64'(pwdata_o), 64'(wdata));
      end
      if (penable_o) acc_seen++;
      if (err_o) err_seen++;
      if (nmi_ready_o) begin
        done = 1'b1; got_lat = cyc; got_rd = nmi_rdata_o;
        check("err_type", 64'(err_type_o), 64'(m_et));
        check("err_addr", 64'(err_addr_o), 64'(m_ea));
        check("psel_resp", 64'(psel_o), 64'h0);
      end
    end
    nmi_valid_i = 1'b0;
    check("latency", 64'(got_lat), 64'(exp_lat));
    check("rdata", 64'(got_rd), 64'(exp_rd));
    check("access_cycles", 64'(acc_seen), 64'(exp_acc));
    check("err_pulses", 64'(err_seen), 64'(exp_et != 2'd0));
  endtask

  initial begin
    int r, wn;
    logic [31:0] a;
    rst_n = 1'b0; nmi_valid_i = 1'b0; nmi_instr_i = 1'b0;
    nmi_addr_i = '0; nmi_wdata_i = '0; nmi_wstrb_i = '0;
    for (int i = 0; i < NS; i++) slv_rd[i] = '0;
    #3;
    check("rst_ctl", 64'({nmi_ready_o, nmi_rdata_o, psel_o, penable_o, pwrite_o, pstrb_o, pprot_o, err_o, err_type_o}), 64'h0);
    check("rst_addr", 64'({paddr_o, err_addr_o}), 64'h0);
    check("rst_wdata", 64'(pwdata_o), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_txn(32'h0300_0040, 4'h0, 32'h0, 1'b0, 0, 1'b0);
    run_txn(32'h0000_0010, 4'h3, 32'hA5A5_A5A5, 1'b1, 2, 1'b0);
    run_txn(32'hF000_0000, 4'h0, 32'h0, 1'b0, 0, 1'b0);
    run_txn(32'h0200_0004, 4'h0, 32'h0, 1'b0, 1, 1'b1);
    run_txn(32'h0700_0000, 4'hF, 32'h1111_2222, 1'b0, 0, 1'b0);
    run_txn(32'h0100_0008, 4'h0, 32'h0, 1'b1, 3, 1'b0);
    run_txn(32'h0400_0000, 4'h0, 32'h0, 1'b0, 255, 1'b0);
    // Late pready after the timeout abort must not produce another completion.
    @(negedge clk); late_rdy = 1'b1;
    @(negedge clk);
    check("late_ready", 64'({nmi_ready_o, err_o, psel_o, penable_o}), 64'h0);
    late_rdy = 1'b0;

    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      a = $urandom;
      if (r < 5)       a[31:24] = 8'(r);
      else if (r == 5) a[31:24] = 8'($urandom_range(5, 15));
      else             a[31:24] = 8'($urandom_range(16, 255));
      wn = $urandom_range(0, 7);
      wn = (wn == 7) ? 255 : (wn % 4);
      run_txn(a, ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom,
              1'($urandom), wn, $urandom_range(0, 5) == 0);
    end

    // Asynchronous reset in the middle of an ACCESS phase
    @(negedge clk);
    wait_n = 3; slverr_flag = 1'b0; rdy_noise = '0; err_noise = '0;
    nmi_valid_i = 1'b1; nmi_addr_i = 32'h0200_0010; nmi_wstrb_i = 4'h0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_penable", 64'(penable_o), 64'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ctl", 64'({nmi_ready_o, nmi_rdata_o, psel_o, penable_o, pwrite_o, pstrb_o, pprot_o, err_o, err_type_o}), 64'h0);
    check("mid_rst_addr", 64'({paddr_o, err_addr_o}), 64'h0);
    nmi_valid_i = 1'b0;
    m_et = 2'd0; m_ea = 32'd0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    run_txn(32'h0300_0000, 4'h0, 32'h0, 1'b0, 1, 1'b0);
    run_txn(32'hC000_0000, 4'h0, 32'h0, 1'b0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nmi_apb_bridge.md
# nmi_apb_bridge

Parametrised NMI-to-APB4 bridge and slave decoder: accepts one native memory interface (valid/ready) transaction at a time, decodes it against a per-slave base/mask map, and runs an APB4 SETUP/ACCESS cycle on the selected slave. It is the successor to the fixed twelve-slave bridge in the peripheral subsystem, where it sits between the core's NMI port and the peripheral APB slaves. It adds the following over that bridge:
- configurable slave count and address map;
- decode-error, PSLVERR and timeout termination;
- an error-capture sideband.

## Interface
Parameters:
- NUM_SLV, 12: number of APB slaves (1..32).
- ADDR_WIDTH, 32: NMI/APB address width.
- SLV_BASE, all zero: packed NUM_SLV*ADDR_WIDTH slave base addresses; slave i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- SLV_MASK, all zero: packed NUM_SLV*ADDR_WIDTH decode masks, same layout.
- TIMEOUT, 256: maximum ACCESS cycles before forced termination; 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned on any error.

Ports:
- clk_i  in  1  bridge clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- nmi_valid_i  in  1  request valid; held until ready.
- nmi_instr_i  in  1  instruction fetch; drives pprot[2].
- nmi_addr_i  in  ADDR_WIDTH  byte address.
- nmi_wdata_i  in  32  write data.
- nmi_wstrb_i  in  4  byte strobes; 0 means read.
- nmi_ready_o  out  1  one-cycle completion pulse.
- nmi_rdata_o  out  32  read data, valid with ready.
- paddr_o  out  ADDR_WIDTH  full request address, shared by all slaves.
- pprot_o  out  3  {instr, 1'b0, 1'b0}.
- psel_o  out  NUM_SLV  one-hot slave select.
- penable_o  out  1  ACCESS phase.
- pwrite_o  out  1  write when wstrb != 0.
- pwdata_o  out  32  write data.
- pstrb_o  out  4  wstrb on writes, 0 on reads.
- prdata_i  in  NUM_SLV*32  per-slave read data.
- pready_i  in  NUM_SLV  per-slave ready.
- pslverr_i  in  NUM_SLV  per-slave error.
- err_o  out  1  one-cycle pulse on any error termination.
- err_type_o  out  2  last error: 0 none, 1 decode, 2 slverr, 3 timeout; sticky.
- err_addr_o  out  ADDR_WIDTH  address of the last error; sticky.

## Operation
- States and transitions:
  - IDLE, on nmi_valid_i with a decode hit: go to SETUP.
  - IDLE, on nmi_valid_i with a decode miss: go to RESP with decode error.
  - SETUP: go to ACCESS.
  - ACCESS, selected pready_i = 1: go to RESP.
  - ACCESS, timeout counter reaches TIMEOUT: go to RESP with timeout error.
  - RESP: go to IDLE.
- Decode: hit[i] = (addr & SLV_MASK[i]) == SLV_BASE[i]. The lowest hitting index wins on overlap. No hit is a decode error.
- Request capture on IDLE exit: paddr, pwrite, pwdata, pstrb, pprot and the slave index are registered. They are held unchanged through SETUP and ACCESS.
- psel is asserted in SETUP and ACCESS; penable only in ACCESS. Both drop in RESP.
- RESP drives nmi_ready_o = 1 for exactly one cycle.
  - nmi_rdata_o = the selected prdata on a clean read, ERR_RDATA on any error.
  - nmi_rdata_o = 0 on a clean write.
- PSLVERR: sampled only together with pready. It sets err type 2, and read data is forced to ERR_RDATA.
- Error termination: err_o pulses in the RESP cycle, and err_type_o and err_addr_o update in that same cycle. They are never cleared except by reset.
- Timeout: the counter clears on SETUP entry and increments each ACCESS cycle without pready. The abort fires when the count equals TIMEOUT-1 and that cycle has no pready, i.e. after TIMEOUT ACCESS cycles. A late pready after the abort is ignored.
- nmi_valid_i is sampled only in IDLE; the request is not re-sampled in RESP.

## Timing
- Reset value of every output is 0, including err_type_o and err_addr_o. Reset applies immediately mid-transfer: psel and penable drop asynchronously and the FSM returns to IDLE.
- Latency, with valid seen at cycle 0:
  - zero-wait-state slave: SETUP at cycle 1, ACCESS at 2, ready at 3;
  - each slave wait state adds one cycle;
  - decode error: ready at cycle 1;
  - timeout: ready at cycle 2+TIMEOUT.
- Back-to-back requests: the next request is sampled in IDLE the cycle after RESP, so the minimum period is 4 cycles.
- All outputs are registered; no combinational path from pready_i to nmi_ready_o.

## Structure
- Package nmi_apb_pkg holds:
  - the state enum {IDLE, SETUP, ACCESS, RESP};
  - the error enum {ERR_NONE, ERR_DECODE, ERR_SLVERR, ERR_TIMEOUT};
  - the default ERR_RDATA constant.
- Sub-module nmi_apb_decoder, purely combinational, turns the address plus SLV_BASE/SLV_MASK into hit, one-hot select and a clog2 index.

## Test plan
- Read of slave 3 (base 0x0300_0000, mask 0xFF00_0000), zero wait, prdata 0x1234_5678 -> psel_o = 0x008; ready at cycle 3; rdata 0x1234_5678; err_o stays 0.
- Write 0xA5A5_A5A5 with wstrb 0x3 to slave 0, 2 wait states -> pstrb_o = 0x3 and pwrite_o = 1 held stable for 3 ACCESS cycles; ready at cycle 5.
- Read of unmapped 0xF000_0000 -> no psel; ready at cycle 1; rdata 0xDEAD_BEEF; err_type 1; err_addr 0xF000_0000.
- Slave asserts pready and pslverr together on a read -> rdata 0xDEAD_BEEF; err_type 2; one err_o pulse.
- With TIMEOUT = 4, slave never ready -> psel/penable drop after 4 ACCESS cycles; ready at cycle 6; err_type 3; a pready on cycle 7 is ignored.
- rst_n_i low during ACCESS -> all outputs 0 immediately; the next request after reset completes normally.
